// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and access sequencer letting a CPU port and a DMA port share one memory port.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_ready,
  output logic [15:0] MARReg,
  output logic [15:0] mdrOut,
  output logic        memWE,
  input  logic [15:0] memOut,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] cnt;
  logic we_q, gnt_id, last_grant;
  logic grant, gnt_dma, fin;
  // gnt_id/last_grant: 0 = CPU, 1 = DMA; a tie goes to whoever did not win last
  always_comb begin
    grant = cpu_req | dma_req;
    gnt_dma = dma_req & (!cpu_req | !last_grant);
    fin = cnt == 3'(WAIT_CYCLES);
    state_nx = state == IDLE ? (grant ? ACCESS : IDLE) :
               state == ACCESS ? (fin ? DONE : ACCESS) : IDLE;
    memWE = state == ACCESS && we_q && cnt == 3'd0;
    cpu_ready = state == DONE && !gnt_id;
    dma_ready = state == DONE && gnt_id;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 3'd0;
      we_q <= 1'b0;
      gnt_id <= 1'b0;
      last_grant <= 1'b1;
      MARReg <= 16'h0;
      mdrOut <= 16'h0;
      cpu_rdata <= 16'h0;
      dma_rdata <= 16'h0;
    end else begin
      state <= state_nx;
      if (state == IDLE && grant) begin
        MARReg <= gnt_dma ? dma_addr : cpu_addr;
        mdrOut <= gnt_dma ? dma_wdata : cpu_wdata;
        we_q <= gnt_dma ? dma_we : cpu_we;
        gnt_id <= gnt_dma;
        last_grant <= gnt_dma;
        cnt <= 3'd0;
      end
      if (state == ACCESS) begin
        if (!fin) cnt <= cnt + 3'd1;
        if (fin && !we_q && !gnt_id) cpu_rdata <= memOut;
        if (fin && !we_q && gnt_id) dma_rdata <= memOut;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven checks on a zero-wait instance plus hand sequences on a three-wait instance.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic cpu_req0, cpu_we0, dma_req0, dma_we0, cpu_ready0, dma_ready0, memWE0, busy0;
  logic [15:0] cpu_addr0, cpu_wdata0, dma_addr0, dma_wdata0, cpu_rdata0, dma_rdata0, MARReg0, mdrOut0, memOut0;
  logic cpu_req3, cpu_we3, dma_req3, dma_we3, cpu_ready3, dma_ready3, memWE3, busy3;
  logic [15:0] cpu_addr3, cpu_wdata3, dma_addr3, dma_wdata3, cpu_rdata3, dma_rdata3, MARReg3, mdrOut3, memOut3;

  mem_arbiter #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req0), .cpu_we(cpu_we0), .cpu_addr(cpu_addr0), .cpu_wdata(cpu_wdata0),
    .cpu_rdata(cpu_rdata0), .cpu_ready(cpu_ready0),
    .dma_req(dma_req0), .dma_we(dma_we0), .dma_addr(dma_addr0), .dma_wdata(dma_wdata0),
    .dma_rdata(dma_rdata0), .dma_ready(dma_ready0),
    .MARReg(MARReg0), .mdrOut(mdrOut0), .memWE(memWE0), .memOut(memOut0), .busy(busy0)
  );
  mem_arbiter #(.WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
    .cpu_rdata(cpu_rdata3), .cpu_ready(cpu_ready3),
    .dma_req(dma_req3), .dma_we(dma_we3), .dma_addr(dma_addr3), .dma_wdata(dma_wdata3),
    .dma_rdata(dma_rdata3), .dma_ready(dma_ready3),
    .MARReg(MARReg3), .mdrOut(mdrOut3), .memWE(memWE3), .memOut(memOut3), .busy(busy3)
  );

  // Memory models; preload port shares the write process with the DUT writes
  logic [15:0] mem0 [65536];
  logic [15:0] mem3 [65536];
  logic pl = 1'b0;
  logic [15:0] pa = 16'h0, pd = 16'h0;
  assign memOut0 = mem0[MARReg0];
  assign memOut3 = mem3[MARReg3];
  always @(posedge clk) begin
    if (memWE0) mem0[MARReg0] <= mdrOut0;
    if (memWE3) mem3[MARReg3] <= mdrOut3;
    if (pl) begin
      mem0[pa] <= pd;
      mem3[pa] <= pd;
    end
  end

  typedef struct {
    logic cr, cw; logic [15:0] ca, cd;
    logic dr, dw; logic [15:0] da, dd;
    logic eb, ew; logic [15:0] em, ed;
    logic ecy, edy; logic [15:0] ecd, edd;
  } vec_t;
  vec_t vecs [23];

  int passed = 0, total = 0;

  function automatic vec_t mk(int cr, cw, ca, cd, dr, dw, da, dd, eb, ew, em, ed, ecy, edy, ecd, edd);
    vec_t v;
    v.cr = 1'(cr); v.cw = 1'(cw); v.ca = 16'(ca); v.cd = 16'(cd);
    v.dr = 1'(dr); v.dw = 1'(dw); v.da = 16'(da); v.dd = 16'(dd);
    v.eb = 1'(eb); v.ew = 1'(ew); v.em = 16'(em); v.ed = 16'(ed);
    v.ecy = 1'(ecy); v.edy = 1'(edy); v.ecd = 16'(ecd); v.edd = 16'(edd);
    return v;
  endfunction

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h, want %h", n, a, e);
    else passed++;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pa = a; pd = d; pl = 1'b1;
    @(negedge clk);
    pl = 1'b0;
  endtask

  task automatic randomize_inputs();
    cpu_req0 = 1'($urandom); cpu_we0 = 1'($urandom); cpu_addr0 = 16'($urandom); cpu_wdata0 = 16'($urandom);
    dma_req0 = 1'($urandom); dma_we0 = 1'($urandom); dma_addr0 = 16'($urandom); dma_wdata0 = 16'($urandom);
    cpu_req3 = 1'($urandom); cpu_we3 = 1'($urandom); cpu_addr3 = 16'($urandom); cpu_wdata3 = 16'($urandom);
    dma_req3 = 1'($urandom); dma_we3 = 1'($urandom); dma_addr3 = 16'($urandom); dma_wdata3 = 16'($urandom);
  endtask

  task automatic zero_inputs();
    {cpu_req0, cpu_we0, cpu_addr0, cpu_wdata0, dma_req0, dma_we0, dma_addr0, dma_wdata0} = '0;
    {cpu_req3, cpu_we3, cpu_addr3, cpu_wdata3, dma_req3, dma_we3, dma_addr3, dma_wdata3} = '0;
  endtask

  initial begin
    reset = 1'b0;
    zero_inputs();
    // Tie from reset: CPU first, alternating, ready every 3 cycles
    vecs[0]  = mk(1,0,'h0010,0, 1,0,'h0020,0, 0,0,'h0000,0, 0,0,'h0000,'h0000);
    vecs[1]  = mk(1,0,'h0010,0, 1,0,'h0020,0, 1,0,'h0010,0, 0,0,'h0000,'h0000);
    vecs[2]  = mk(1,0,'h0010,0, 1,0,'h0020,0, 1,0,'h0010,0, 1,0,'h1111,'h0000);
    vecs[3]  = mk(1,0,'h0010,0, 1,0,'h0020,0, 0,0,'h0010,0, 0,0,'h1111,'h0000);
    vecs[4]  = mk(1,0,'h0010,0, 1,0,'h0020,0, 1,0,'h0020,0, 0,0,'h1111,'h0000);
    vecs[5]  = mk(1,0,'h0010,0, 1,0,'h0020,0, 1,0,'h0020,0, 0,1,'h1111,'h2222);
    vecs[6]  = mk(1,0,'h0010,0, 1,0,'h0020,0, 0,0,'h0020,0, 0,0,'h1111,'h2222);
    vecs[7]  = mk(1,0,'h0010,0, 1,0,'h0020,0, 1,0,'h0010,0, 0,0,'h1111,'h2222);
    vecs[8]  = mk(1,0,'h0010,0, 1,0,'h0020,0, 1,0,'h0010,0, 1,0,'h1111,'h2222);
    vecs[9]  = mk(1,0,'h0010,0, 1,0,'h0020,0, 0,0,'h0010,0, 0,0,'h1111,'h2222);
    vecs[10] = mk(1,0,'h0010,0, 1,0,'h0020,0, 1,0,'h0020,0, 0,0,'h1111,'h2222);
    vecs[11] = mk(1,0,'h0010,0, 1,0,'h0020,0, 1,0,'h0020,0, 0,1,'h1111,'h2222);
    vecs[12] = mk(0,0,'h0000,0, 0,0,'h0000,0, 0,0,'h0020,0, 0,0,'h1111,'h2222);
    // CPU write 0xBEEF to 0x3000 then read it back
    vecs[13] = mk(1,1,'h3000,'hBEEF, 0,0,0,0, 0,0,'h0020,0,      0,0,'h1111,'h2222);
    vecs[14] = mk(1,1,'h3000,'hBEEF, 0,0,0,0, 1,1,'h3000,'hBEEF, 0,0,'h1111,'h2222);
    vecs[15] = mk(1,1,'h3000,'hBEEF, 0,0,0,0, 1,0,'h3000,'hBEEF, 1,0,'h1111,'h2222);
    vecs[16] = mk(1,0,'h3000,0,      0,0,0,0, 0,0,'h3000,'hBEEF, 0,0,'h1111,'h2222);
    vecs[17] = mk(1,0,'h3000,0,      0,0,0,0, 1,0,'h3000,0,      0,0,'h1111,'h2222);
    vecs[18] = mk(1,0,'h3000,0,      0,0,0,0, 1,0,'h3000,0,      1,0,'h BEEF,'h2222);
    // DMA address moves after grant; latched 0x0100 must be used
    vecs[19] = mk(0,0,0,0, 1,0,'h0100,0, 0,0,'h3000,0, 0,0,'hBEEF,'h2222);
    vecs[20] = mk(0,0,0,0, 1,0,'h0200,0, 1,0,'h0100,0, 0,0,'hBEEF,'h2222);
    vecs[21] = mk(0,0,0,0, 1,0,'h0200,0, 1,0,'h0100,0, 0,1,'hBEEF,'h0A0A);
    vecs[22] = mk(0,0,0,0, 0,0,0,0,      0,0,'h0100,0, 0,0,'hBEEF,'h0A0A);

    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      randomize_inputs();
      @(negedge clk);
    end
    randomize_inputs();
    reset = 1'b0;
    #1;
    chk("rst MARReg0", MARReg0, 16'h0);      chk("rst mdrOut0", mdrOut0, 16'h0);
    chk("rst memWE0", 16'(memWE0), 16'h0);   chk("rst busy0", 16'(busy0), 16'h0);
    chk("rst cpu_rdata0", cpu_rdata0, 16'h0); chk("rst dma_rdata0", dma_rdata0, 16'h0);
    chk("rst cpu_ready0", 16'(cpu_ready0), 16'h0); chk("rst dma_ready0", 16'(dma_ready0), 16'h0);
    chk("rst MARReg3", MARReg3, 16'h0);      chk("rst mdrOut3", mdrOut3, 16'h0);
    chk("rst memWE3", 16'(memWE3), 16'h0);   chk("rst busy3", 16'(busy3), 16'h0);
    chk("rst cpu_rdata3", cpu_rdata3, 16'h0); chk("rst dma_rdata3", dma_rdata3, 16'h0);
    chk("rst cpu_ready3", 16'(cpu_ready3), 16'h0); chk("rst dma_ready3", 16'(dma_ready3), 16'h0);
    @(negedge clk);
    zero_inputs();
    preload(16'h0010, 16'h1111);
    preload(16'h0020, 16'h2222);
    preload(16'h0100, 16'h0A0A);
    preload(16'h0200, 16'h0B0B);
    preload(16'h1234, 16'h5A5A);
    preload(16'h4000, 16'h0000);
    reset = 1'b1;
    #1;
    chk("post-rst memWE0", 16'(memWE0), 16'h0);
    chk("post-rst busy0", 16'(busy0), 16'h0);
    @(negedge clk);
    chk("idle memWE0", 16'(memWE0), 16'h0);
    chk("idle memWE3", 16'(memWE3), 16'h0);

    for (int i = 0; i < 23; i++) begin
      cpu_req0 = vecs[i].cr; cpu_we0 = vecs[i].cw; cpu_addr0 = vecs[i].ca; cpu_wdata0 = vecs[i].cd;
      dma_req0 = vecs[i].dr; dma_we0 = vecs[i].dw; dma_addr0 = vecs[i].da; dma_wdata0 = vecs[i].dd;
      #1;
      chk($sformatf("v%0d busy", i), 16'(busy0), 16'(vecs[i].eb));
      chk($sformatf("v%0d memWE", i), 16'(memWE0), 16'(vecs[i].ew));
      chk($sformatf("v%0d MARReg", i), MARReg0, vecs[i].em);
      chk($sformatf("v%0d mdrOut", i), mdrOut0, vecs[i].ed);
      chk($sformatf("v%0d cpu_ready", i), 16'(cpu_ready0), 16'(vecs[i].ecy));
      chk($sformatf("v%0d dma_ready", i), 16'(dma_ready0), 16'(vecs[i].edy));
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata0, vecs[i].ecd);
      chk($sformatf("v%0d dma_rdata", i), dma_rdata0, vecs[i].edd);
      @(negedge clk);
    end
    chk("mem0 0x3000", mem0[16'h3000], 16'hBEEF);

    // Three wait states: DMA read of 0x1234, ready in cycle 5
    for (int k = 0; k < 7; k++) begin
      dma_req3 = k <= 5;
      dma_addr3 = 16'h1234;
      #1;
      chk($sformatf("ws c%0d busy", k), 16'(busy3), 16'(k >= 1 && k <= 5));
      chk($sformatf("ws c%0d dma_ready", k), 16'(dma_ready3), 16'(k == 5));
      chk($sformatf("ws c%0d cpu_ready", k), 16'(cpu_ready3), 16'h0);
      chk($sformatf("ws c%0d dma_rdata", k), dma_rdata3, k >= 5 ? 16'h5A5A : 16'h0000);
      @(negedge clk);
    end

    // Reset during the second ACCESS cycle of a CPU write
    cpu_req3 = 1'b1; cpu_we3 = 1'b1; cpu_addr3 = 16'h4000; cpu_wdata3 = 16'h7777;
    @(negedge clk);
    chk("rw memWE c1", 16'(memWE3), 16'h1);
    chk("rw MARReg c1", MARReg3, 16'h4000);
    chk("rw mdrOut c1", mdrOut3, 16'h7777);
    @(negedge clk);
    chk("rw busy c2", 16'(busy3), 16'h1);
    chk("rw memWE c2", 16'(memWE3), 16'h0);
    reset = 1'b0;
    #1;
    chk("rw memWE in rst", 16'(memWE3), 16'h0);
    chk("rw busy in rst", 16'(busy3), 16'h0);
    chk("rw cpu_ready in rst", 16'(cpu_ready3), 16'h0);
    cpu_req3 = 1'b0; cpu_we3 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rw after c%0d cpu_ready", k), 16'(cpu_ready3), 16'h0);
      chk($sformatf("rw after c%0d busy", k), 16'(busy3), 16'h0);
    end
    chk("rw cpu_rdata", cpu_rdata3, 16'h0);
    chk("rw mem 0x4000", mem3[16'h4000], 16'h7777);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer for the single-port 64K×16 LC-3 memory. Two requesters share the one memory port: the CPU datapath (MAR/MDR side) and a DMA/IO agent. The block latches one request at a time, drives the memory's address/data/write-enable, waits a configurable number of cycles, then returns read data with a one-cycle ready pulse. Arbitration is round-robin when both requesters ask in the same cycle.

## Interface
- WAIT_CYCLES, 0, extra ACCESS cycles before completion (legal range 0..7).
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- cpu_req  in  1  CPU access request; held high until cpu_ready is sampled high.
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req is high.
- cpu_addr  in  16  word address.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  read data; updated only on completion of a CPU read.
- cpu_ready  out  1  one-cycle completion pulse for CPU.
- dma_req, dma_we, dma_addr[15:0], dma_wdata[15:0], dma_rdata[15:0], dma_ready: same as the cpu_ signals, DMA side.
- MARReg  out  16  memory address (registered).
- mdrOut  out  16  memory write data (registered).
- memWE  out  1  memory write enable; the memory writes at the posedge where this is high.
- memOut  in  16  combinational memory read data at MARReg.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: remain in IDLE.
  - Exactly one request: grant that requester.
  - Both requests: grant the requester that is not `last_grant`.
  - On a grant, at the same edge: latch addr into MARReg, wdata into mdrOut, we into we_q, record `gnt_id`, set `last_grant <= gnt_id`, clear cnt, go to ACCESS.
- ACCESS:
  - memWE = we_q & (cnt == 0). Each write produces exactly one memWE cycle.
  - If cnt == WAIT_CYCLES: if !we_q, capture memOut into the granted port's rdata; go to DONE.
  - Otherwise cnt <= cnt + 1. cnt is 3 bits.
- DONE:
  - The granted port's ready = 1 for this single cycle.
  - Go to IDLE unconditionally.
- Requester rule:
  - A requester deasserts req at the edge where it samples its ready = 1.
  - If req is still high in the following IDLE cycle, that is a new request.
- The granted requester's addr/we/wdata may change after the grant; the block ignores them because the values are latched.
- The non-granted requester's req stays high. It is served next, so it waits at most one full transaction.
- rdata of a port holds its value through writes and through the other port's transactions.
- Only the granted port's ready pulses; the other ready stays 0.

## Timing
- Reset values (asynchronous, while reset = 0):
  - state = IDLE, cnt = 0, last_grant = DMA (so the CPU wins the first tie).
  - MARReg = 0, mdrOut = 0, memWE = 0, we_q = 0.
  - cpu_rdata = 0, dma_rdata = 0, cpu_ready = 0, dma_ready = 0, busy = 0.
- Latency, with req first sampled in IDLE at cycle 0:
  - ACCESS occupies cycles 1 .. 1+WAIT_CYCLES.
  - ready is high in cycle 2+WAIT_CYCLES.
  - IDLE resumes in cycle 3+WAIT_CYCLES.
  - With WAIT_CYCLES=0: ready is high in cycle 2, and transactions issue at most one every 3 cycles.
- The memory write occurs at the edge ending the first ACCESS cycle. A read of the same address in a later transaction returns the new value.
- Reset asserted mid-transaction:
  - memWE drops immediately.
  - No ready pulse is produced and no rdata is updated.
  - The transaction is lost; the requester must re-request after reset releases.
- Reset deassertion: the first request is sampled at the first rising edge with reset = 1.
- Requests arriving during ACCESS/DONE are not sampled until IDLE.

## Test plan
- Reset check: drive reset=0 mid-sim with random inputs. All outputs must read 0 and busy=0. Release reset, then let one idle cycle pass: memWE stays 0.
- CPU write/read, WAIT_CYCLES=0:
  - Write 0xBEEF to 0x3000. memWE is high for exactly one cycle with MARReg=0x3000 and mdrOut=0xBEEF. cpu_ready is high at cycle 2.
  - Then read 0x3000. cpu_rdata=0xBEEF at the cycle of cpu_ready.
- Tie arbitration:
  - cpu_req and dma_req held high from reset, reading 0x0010 (CPU) and 0x0020 (DMA) continuously.
  - Grants alternate CPU, DMA, CPU, DMA, with the CPU first. A ready pulse occurs every 3 cycles, alternating ports.
- Wait states, WAIT_CYCLES=3: DMA read of 0x1234 preloaded with 0x5A5A. dma_ready is high at cycle 5, dma_rdata=0x5A5A, and busy is high for cycles 1..5.
- Reset mid-write: CPU write to 0x4000 with WAIT_CYCLES=3. Assert reset during the second ACCESS cycle. cpu_ready never pulses and the state returns to IDLE. The memory holds the new value, since the write edge already passed.
- Address change after grant: DMA changes dma_addr from 0x0100 to 0x0200 in the cycle after the grant. MARReg stays 0x0100 for the whole transaction, and cpu_rdata is unchanged.
